// File: rtl/alu_seq_pkg.sv
// Shared types and widths for the operand sequencer: FSM states, ALU opcodes,
// and the combinational result function used when the operation is captured.
package alu_seq_pkg;

  localparam int OPERAND_W = 5;
  localparam int RESULT_W  = 6;

  typedef enum logic [1:0] {
    ST_WAIT_A  = 2'd0,
    ST_WAIT_B  = 2'd1,
    ST_WAIT_OP = 2'd2,
    ST_SHOW    = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    OP_ADD     = 2'b00,
    OP_ABSDIFF = 2'b01,
    OP_MAX     = 2'b10,
    OP_CMP     = 2'b11
  } op_e;

  typedef struct packed {
    logic [RESULT_W-1:0] value;
    logic                neg;
  } alu_out_t;

  function automatic alu_out_t alu_compute(
    input logic [OPERAND_W-1:0] a,
    input logic [OPERAND_W-1:0] b,
    input op_e                  op
  );
    alu_out_t r;
    r.value = '0;
    r.neg   = 1'b0;
    case (op)
      OP_ADD:     r.value = {1'b0, a} + {1'b0, b};
      OP_ABSDIFF: begin
        r.value = (a < b) ? {1'b0, b - a} : {1'b0, a - b};
        r.neg   = (a < b);
      end
      OP_MAX:     r.value = (a < b) ? {1'b0, b} : {1'b0, a};
      OP_CMP:     r.value = (a < b) ? 6'd0 : ((a == b) ? 6'd1 : 6'd2);
      default:    r.value = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Active-low pushbutton conditioner: 2-flop synchroniser, stable-level
// debounce counter and a one-cycle press pulse on the debounced 1->0 edge.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clock,
  input  logic rstIn,
  input  logic buttonIn,
  output logic pressPulse
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             deb_q, deb_d;
  logic             armed_q, armed_d;
  logic             press_q, press_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Until a full debounced release has been seen after reset, the counter
  // measures stable release time so a button held through reset cannot fire.
  always_comb begin
    cnt_d   = '0;
    deb_d   = deb_q;
    armed_d = armed_q;
    press_d = 1'b0;
    if (!armed_q) begin
      if (sync2_q) begin
        if (cnt_q == CNT_LAST) armed_d = 1'b1;
        else                   cnt_d   = cnt_q + 1'b1;
      end
    end else if (sync2_q != deb_q) begin
      if (cnt_q == CNT_LAST) begin
        deb_d   = sync2_q;
        press_d = deb_q & ~sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge rstIn) begin
    if (!rstIn) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      deb_q   <= 1'b1;
      armed_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= buttonIn;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      armed_q <= armed_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pressPulse = press_q;

endmodule

// File: rtl/alu_operand_sequencer.sv
// Button-stepped operand entry: capture A, B, then an operation, show the
// registered result, and clear on the next press.
module alu_operand_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic                 clock,
  input  logic                 rstIn,
  input  logic                 buttonIn,
  input  logic [OPERAND_W-1:0] swIn,
  input  logic [1:0]           opSel,
  output logic [RESULT_W-1:0]  sixBit,
  output logic [3:0]           stageLed,
  output logic                 negFlag
);

  logic press;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn (
    .clock     (clock),
    .rstIn     (rstIn),
    .buttonIn  (buttonIn),
    .pressPulse(press)
  );

  state_e               state_q, state_d;
  logic [OPERAND_W-1:0] a_q, a_d, b_q, b_d;
  logic [RESULT_W-1:0]  result_q, result_d;
  logic                 neg_q, neg_d;
  alu_out_t             alu_res;

  assign alu_res = alu_compute(a_q, b_q, op_e'(opSel));

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    neg_d    = neg_q;
    if (press) begin
      case (state_q)
        ST_WAIT_A: begin
          a_d     = swIn;
          state_d = ST_WAIT_B;
        end
        ST_WAIT_B: begin
          b_d     = swIn;
          state_d = ST_WAIT_OP;
        end
        ST_WAIT_OP: begin
          result_d = alu_res.value;
          neg_d    = alu_res.neg;
          state_d  = ST_SHOW;
        end
        default: begin
          a_d      = '0;
          b_d      = '0;
          result_d = '0;
          neg_d    = 1'b0;
          state_d  = ST_WAIT_A;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge rstIn) begin
    if (!rstIn) begin
      state_q  <= ST_WAIT_A;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      neg_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      neg_q    <= neg_d;
    end
  end

  always_comb begin
    stageLed = 4'b0001;
    case (state_q)
      ST_WAIT_A:  stageLed = 4'b0001;
      ST_WAIT_B:  stageLed = 4'b0010;
      ST_WAIT_OP: stageLed = 4'b0100;
      default:    stageLed = 4'b1000;
    endcase
  end

  // Entry states echo the switches live; SHOW freezes on the captured result.
  assign sixBit  = (state_q == ST_SHOW) ? result_q : {1'b0, swIn};
  assign negFlag = (state_q == ST_SHOW) & neg_q;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Self-checking bench for alu_operand_sequencer with a short debounce window.
module tb_alu_operand_sequencer;

  logic       clock = 1'b0;
  logic       rstIn;
  logic       buttonIn;
  logic [4:0] swIn;
  logic [1:0] opSel;
  logic [5:0] sixBit;
  logic [3:0] stageLed;
  logic       negFlag;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clock = ~clock;

  alu_operand_sequencer #(
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clock   (clock),
    .rstIn   (rstIn),
    .buttonIn(buttonIn),
    .swIn    (swIn),
    .opSel   (opSel),
    .sixBit  (sixBit),
    .stageLed(stageLed),
    .negFlag (negFlag)
  );

  typedef struct {
    logic [4:0] a;
    logic [4:0] b;
    logic [1:0] op;
    logic [5:0] res;
    logic       neg;
  } vec_t;

  typedef struct {
    logic [5:0] res;
    logic       neg;
  } exp_t;

  exp_t sb_q[$];
  vec_t vecs[12];

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_errors++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, req);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Hold the button until the stage moves (bounded), release, and confirm
  // that exactly one advance happened across the whole press.
  task automatic press(input logic [4:0] sw, input logic [3:0] exp_stage);
    logic [3:0] old;
    int waited;
    swIn     = sw;
    old      = stageLed;
    buttonIn = 1'b0;
    waited   = 0;
    while (stageLed == old && waited < 30) begin
      tick(1);
      waited++;
    end
    check("press_stage", int'(stageLed), int'(exp_stage));
    buttonIn = 1'b1;
    tick(12);
    check("press_single_advance", int'(stageLed), int'(exp_stage));
  endtask

  initial begin
    exp_t e;
    int   adv;
    logic [3:0] prev;

    vecs[0]  = '{5'd25, 5'd30, 2'b00, 6'd55, 1'b0};
    vecs[1]  = '{5'd3,  5'd10, 2'b01, 6'd7,  1'b1};
    vecs[2]  = '{5'd10, 5'd3,  2'b01, 6'd7,  1'b0};
    vecs[3]  = '{5'd17, 5'd17, 2'b01, 6'd0,  1'b0};
    vecs[4]  = '{5'd17, 5'd17, 2'b11, 6'd1,  1'b0};
    vecs[5]  = '{5'd20, 5'd9,  2'b11, 6'd2,  1'b0};
    vecs[6]  = '{5'd3,  5'd10, 2'b11, 6'd0,  1'b0};
    vecs[7]  = '{5'd12, 5'd29, 2'b10, 6'd29, 1'b0};
    vecs[8]  = '{5'd29, 5'd12, 2'b10, 6'd29, 1'b0};
    vecs[9]  = '{5'd8,  5'd8,  2'b10, 6'd8,  1'b0};
    vecs[10] = '{5'd31, 5'd31, 2'b00, 6'd62, 1'b0};
    vecs[11] = '{5'd0,  5'd0,  2'b00, 6'd0,  1'b0};

    rstIn    = 1'b0;
    buttonIn = 1'b1;
    swIn     = 5'd5;
    opSel    = 2'b00;
    tick(3);
    check("reset_stage", int'(stageLed), 1);
    check("reset_sixbit", int'(sixBit), 5);
    check("reset_neg", int'(negFlag), 0);
    rstIn = 1'b1;
    tick(10);

    for (int i = 0; i < 12; i++) begin
      opSel = 2'b00;
      press(vecs[i].a, 4'b0010);
      swIn = vecs[i].b;
      tick(1);
      check("live_sixbit", int'(sixBit), int'({1'b0, vecs[i].b}));
      check("live_neg", int'(negFlag), 0);
      press(vecs[i].b, 4'b0100);
      opSel = vecs[i].op;
      e.res = vecs[i].res;
      e.neg = vecs[i].neg;
      sb_q.push_back(e);
      press(5'd0, 4'b1000);
      if (sb_q.size() == 0) begin
        check("scoreboard_empty", 1, 0);
      end else begin
        e = sb_q.pop_front();
        check("show_result", int'(sixBit), int'(e.res));
        check("show_neg", int'(negFlag), int'(e.neg));
      end
      press(5'd13, 4'b0001);
      check("clear_sixbit", int'(sixBit), 13);
      check("clear_neg", int'(negFlag), 0);
    end

    // Bounce: 2-cycle toggling never satisfies the window; the final low does once.
    adv  = 0;
    prev = stageLed;
    for (int i = 0; i < 20; i++) begin
      buttonIn = (i % 2 == 0) ? 1'b0 : 1'b1;
      for (int k = 0; k < 2; k++) begin
        tick(1);
        if (stageLed != prev) adv++;
        prev = stageLed;
      end
    end
    buttonIn = 1'b0;
    for (int k = 0; k < 130; k++) begin
      tick(1);
      if (stageLed != prev) adv++;
      prev = stageLed;
    end
    check("bounce_advances", adv, 1);
    check("bounce_stage", int'(stageLed), 2);
    buttonIn = 1'b1;
    tick(12);

    // Reset in WAIT_OP with the button held down.
    press(5'd7, 4'b0100);
    swIn     = 5'd21;
    buttonIn = 1'b0;
    tick(2);
    rstIn = 1'b0;
    #1;
    check("rst_mid_stage", int'(stageLed), 1);
    check("rst_mid_sixbit", int'(sixBit), 21);
    tick(3);
    rstIn = 1'b1;
    tick(40);
    check("rst_held_no_advance", int'(stageLed), 1);
    buttonIn = 1'b1;
    tick(12);
    check("rst_release_no_advance", int'(stageLed), 1);

    // SHOW stability with 31+31.
    press(5'd31, 4'b0010);
    press(5'd31, 4'b0100);
    opSel = 2'b00;
    press(5'd0, 4'b1000);
    for (int i = 0; i < 20; i++) begin
      swIn  = 5'($urandom_range(0, 31));
      opSel = 2'($urandom_range(0, 3));
      tick(1);
      check("show_stable", int'(sixBit), 62);
    end
    press(5'd4, 4'b0001);
    check("final_sixbit", int'(sixBit), 4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
